mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : identity of the requester that owns (or last owned) the bus
//   WDOG_W      : width of the per-access watchdog counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port Wishbone slave between the fetch stage
// (instr_* port) and the memory stage (wb_* port). One access at a time,
// round-robin under contention, and a watchdog that aborts an access the
// slave never acknowledges.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   instr_addr/stb             fetch request (held until instr_ack)
//   instr_ack/err, instr       fetch completion pulse, timeout flag, data
//   wb_cyc/stb/wr_en/addr/
//   wb_wr_data/wr_sel          data-port Wishbone request
//   wb_ack/err/stall,
//   wb_rd_data                 data-port completion, timeout, stall, data
//   m_cyc/stb/wr_en/addr/
//   m_wr_data/wr_sel           downstream Wishbone request
//   m_ack/stall, m_rd_data     downstream slave response
//
// state | meaning
// IDLE  | no access in flight; arbitrate and grant
// INSTR | fetch access owns the downstream bus
// DATA  | data access owns the downstream bus
// DONE  | requester ack/err pulse visible; blocks immediate re-grant
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_stb,
  output logic                  instr_ack,
  output logic                  instr_err,
  output logic [31:0]           instr,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_wr_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_wr_data,
  input  logic [3:0]            wb_wr_sel,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_stall,
  output logic [31:0]           wb_rd_data,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wr_data,
  output logic [3:0]            m_wr_sel,
  input  logic                  m_ack,
  input  logic                  m_stall,
  input  logic [31:0]           m_rd_data
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t              state, state_nxt;
  grant_t                  last_grant, last_grant_nxt;
  logic [WDOG_W-1:0]       wdog, wdog_nxt;

  logic                    m_cyc_nxt, m_stb_nxt, m_wr_en_nxt;
  logic [ADDR_WIDTH-1:0]   m_addr_nxt;
  logic [31:0]             m_wr_data_nxt;
  logic [3:0]              m_wr_sel_nxt;
  logic                    instr_ack_nxt, instr_err_nxt;
  logic [31:0]             instr_nxt;
  logic                    wb_ack_nxt, wb_err_nxt;
  logic [31:0]             wb_rd_data_nxt;

  logic data_req;
  logic instr_wins;

  assign data_req   = wb_cyc & wb_stb;
  assign instr_wins = instr_stb & (~data_req | (last_grant == GRANT_DATA));

  // Gated by rst_n so the stall output reads 0 during reset even if the
  // fetch port is still requesting.
  assign wb_stall = rst_n & ((state != IDLE) | instr_wins);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wdog_nxt       = wdog;
    m_cyc_nxt      = m_cyc;
    m_stb_nxt      = m_stb;
    m_wr_en_nxt    = m_wr_en;
    m_addr_nxt     = m_addr;
    m_wr_data_nxt  = m_wr_data;
    m_wr_sel_nxt   = m_wr_sel;
    instr_ack_nxt  = 1'b0;
    instr_err_nxt  = 1'b0;
    instr_nxt      = instr;
    wb_ack_nxt     = 1'b0;
    wb_err_nxt     = 1'b0;
    wb_rd_data_nxt = wb_rd_data;

    case (state)
      IDLE: begin
        if (instr_wins) begin
          state_nxt      = INSTR;
          last_grant_nxt = GRANT_INSTR;
          wdog_nxt       = '0;
          m_cyc_nxt      = 1'b1;
          m_stb_nxt      = 1'b1;
          m_wr_en_nxt    = 1'b0;
          m_addr_nxt     = instr_addr;
          m_wr_data_nxt  = '0;
          m_wr_sel_nxt   = '0;
        end else if (data_req) begin
          state_nxt      = DATA;
          last_grant_nxt = GRANT_DATA;
          wdog_nxt       = '0;
          m_cyc_nxt      = 1'b1;
          m_stb_nxt      = 1'b1;
          m_wr_en_nxt    = wb_wr_en;
          m_addr_nxt     = wb_addr;
          m_wr_data_nxt  = wb_wr_data;
          m_wr_sel_nxt   = wb_wr_sel;
        end
      end

      INSTR, DATA: begin
        wdog_nxt = wdog + WDOG_W'(1);
        if (m_stb & ~m_stall)
          m_stb_nxt = 1'b0;

        if ((state == DATA) & ~wb_cyc) begin
          // Requester abandoned the cycle: release the slave, no ack.
          m_cyc_nxt = 1'b0;
          m_stb_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (m_ack) begin
          // Checked before the watchdog so a same-cycle ack completes cleanly.
          m_cyc_nxt = 1'b0;
          m_stb_nxt = 1'b0;
          state_nxt = DONE;
          if (state == INSTR) begin
            instr_nxt     = m_rd_data;
            instr_ack_nxt = 1'b1;
          end else begin
            wb_rd_data_nxt = m_rd_data;
            wb_ack_nxt     = 1'b1;
          end
        end else if (wdog == WDOG_LAST) begin
          m_cyc_nxt = 1'b0;
          m_stb_nxt = 1'b0;
          state_nxt = DONE;
          if (state == INSTR) begin
            instr_nxt     = '0;
            instr_ack_nxt = 1'b1;
            instr_err_nxt = 1'b1;
          end else begin
            wb_rd_data_nxt = '0;
            wb_ack_nxt     = 1'b1;
            wb_err_nxt     = 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_DATA;
      wdog       <= '0;
      m_cyc      <= 1'b0;
      m_stb      <= 1'b0;
      m_wr_en    <= 1'b0;
      m_addr     <= '0;
      m_wr_data  <= '0;
      m_wr_sel   <= '0;
      instr_ack  <= 1'b0;
      instr_err  <= 1'b0;
      instr      <= '0;
      wb_ack     <= 1'b0;
      wb_err     <= 1'b0;
      wb_rd_data <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wdog       <= wdog_nxt;
      m_cyc      <= m_cyc_nxt;
      m_stb      <= m_stb_nxt;
      m_wr_en    <= m_wr_en_nxt;
      m_addr     <= m_addr_nxt;
      m_wr_data  <= m_wr_data_nxt;
      m_wr_sel   <= m_wr_sel_nxt;
      instr_ack  <= instr_ack_nxt;
      instr_err  <= instr_err_nxt;
      instr      <= instr_nxt;
      wb_ack     <= wb_ack_nxt;
      wb_err     <= wb_err_nxt;
      wb_rd_data <= wb_rd_data_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a small
// behavioural Wishbone memory (configurable stall count / no-ack mode).
module tb_mem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] instr_addr = '0;
  logic          instr_stb = 1'b0;
  logic          instr_ack, instr_err;
  logic [31:0]   instr;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_wr_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [31:0]   wb_wr_data = '0;
  logic [3:0]    wb_wr_sel = '0;
  logic          wb_ack, wb_err, wb_stall;
  logic [31:0]   wb_rd_data;
  logic          m_cyc, m_stb, m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wr_data;
  logic [3:0]    m_wr_sel;
  logic          m_ack, m_stall;
  logic [31:0]   m_rd_data = '0;

  mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_addr(instr_addr), .instr_stb(instr_stb), .instr_ack(instr_ack),
    .instr_err(instr_err), .instr(instr),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
    .wb_wr_data(wb_wr_data), .wb_wr_sel(wb_wr_sel), .wb_ack(wb_ack),
    .wb_err(wb_err), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_wr_en(m_wr_en), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_sel(m_wr_sel),
    .m_ack(m_ack), .m_stall(m_stall), .m_rd_data(m_rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          stall_cfg = 0;
  bit          no_ack_cfg = 1'b0;
  logic        stray_ack = 1'b0;
  int          stall_cnt = 0;
  logic        m_ack_s = 1'b0;
  logic [31:0] mem [256];
  bit          written [256];

  assign m_stall = m_stb && (stall_cnt < stall_cfg);
  assign m_ack   = m_ack_s | stray_ack;

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'd12:   return 32'h0000_00ab;
      8'd16:   return 32'h5a5a_c3c3;
      8'd20:   return 32'h0bad_f00d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [7:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    m_ack_s <= 1'b0;
    if (!m_cyc) stall_cnt <= 0;
    else if (m_stall) stall_cnt <= stall_cnt + 1;
    if (m_cyc && m_stb && !m_stall && !no_ack_cfg) begin
      m_ack_s   <= 1'b1;
      m_rd_data <= rd_word(m_addr[9:2]);
      if (m_wr_en) begin
        mem[m_addr[9:2]]     <= merge(rd_word(m_addr[9:2]), m_wr_data, m_wr_sel);
        written[m_addr[9:2]] <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] hold_instr = '0;
  logic [31:0] hold_wb = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {instr_ack, instr_err, instr, wb_ack, wb_err, wb_stall, wb_rd_data,
            m_cyc, m_stb, m_wr_en, m_addr, m_wr_data, m_wr_sel};
  endfunction

  typedef struct {
    bit          is_data;
    bit          wr_en;
    logic [9:0]  addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    int          stall;
    bit          no_ack;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input int i, input vec_t v);
    int lat, stall_bad, wr_bad;
    bit got;
    logic ack_v, err_v;
    logic [31:0] rd_v;
    stall_cfg  = v.stall;
    no_ack_cfg = v.no_ack;
    if (v.is_data) begin
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_wr_en = v.wr_en; wb_addr = v.addr;
      wb_wr_data = v.wr_data; wb_wr_sel = v.wr_sel;
    end else begin
      instr_stb = 1'b1; instr_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d_idle_stall", i), 128'(wb_stall), 128'(!v.is_data));
    lat = 0; got = 1'b0; stall_bad = 0; wr_bad = 0;
    ack_v = 1'b0; err_v = 1'b0; rd_v = '0;
    while (!got && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (!wb_stall) stall_bad++;
      if (!v.is_data && (m_wr_en || m_wr_sel != 4'h0)) wr_bad++;
      if (v.is_data) begin ack_v = wb_ack; err_v = wb_err; rd_v = wb_rd_data; end
      else begin ack_v = instr_ack; err_v = instr_err; rd_v = instr; end
      if (ack_v) got = 1'b1;
    end
    chk($sformatf("v%0d_latency", i), 128'(lat), 128'(v.exp_lat));
    chk($sformatf("v%0d_rd_data", i), 128'(rd_v), 128'(v.exp_rd));
    chk($sformatf("v%0d_err", i), 128'(err_v), 128'(v.exp_err));
    chk($sformatf("v%0d_busy_stall", i), 128'(stall_bad), 128'(0));
    if (v.is_data) begin
      chk($sformatf("v%0d_instr_hold", i), 128'(instr), 128'(hold_instr));
      hold_wb = v.exp_rd;
    end else begin
      chk($sformatf("v%0d_instr_no_write", i), 128'(wr_bad), 128'(0));
      chk($sformatf("v%0d_wb_hold", i), 128'(wb_rd_data), 128'(hold_wb));
      hold_instr = v.exp_rd;
    end
    instr_stb = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse_end", i), 128'({instr_ack, wb_ack, instr_err, wb_err, m_cyc}), 128'(0));
    no_ack_cfg = 1'b0;
    stall_cfg  = 0;
  endtask

  task automatic tie_test();
    int n, cyc;
    bit re_i, re_d;
    bit ord[4];
    bit exp_ord[4];
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
    ord     = '{1'b1, 1'b1, 1'b1, 1'b1};
    instr_addr = 10'h30; wb_addr = 10'h34; wb_wr_en = 1'b0;
    instr_stb = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    #1;
    chk("tie_stall_instr_wins", 128'(wb_stall), 128'(1));
    n = 0; cyc = 0; re_i = 1'b0; re_d = 1'b0;
    while (n < 4 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (re_i) begin instr_stb = 1'b1; re_i = 1'b0; end
      if (re_d) begin wb_stb = 1'b1; re_d = 1'b0; end
      if (instr_ack) begin
        ord[n] = 1'b0; n++; instr_stb = 1'b0; re_i = 1'b1;
      end else if (wb_ack) begin
        ord[n] = 1'b1; n++; wb_stb = 1'b0; re_d = 1'b1;
      end
    end
    instr_stb = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("tie_ack_count", 128'(n), 128'(4));
    for (int k = 0; k < 4; k++)
      chk($sformatf("tie_order_%0d", k), 128'(ord[k]), 128'(exp_ord[k]));
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    vecs[0]  = '{1'b0, 1'b0, 10'h30, 32'h0,         4'h0,  0, 1'b0, 32'h0000_00ab, 1'b0,  3};
    vecs[1]  = '{1'b1, 1'b1, 10'h35, 32'h1234_5678, 4'hc,  0, 1'b0, 32'h0000_0000, 1'b0,  3};
    vecs[2]  = '{1'b1, 1'b0, 10'h34, 32'h0,         4'h0,  0, 1'b0, 32'h1234_0000, 1'b0,  3};
    vecs[3]  = '{1'b0, 1'b0, 10'h34, 32'h0,         4'h0,  0, 1'b0, 32'h1234_0000, 1'b0,  3};
    vecs[4]  = '{1'b0, 1'b0, 10'h40, 32'h0,         4'h0,  3, 1'b0, 32'h5a5a_c3c3, 1'b0,  6};
    vecs[5]  = '{1'b1, 1'b0, 10'h50, 32'h0,         4'h0,  1, 1'b0, 32'h0bad_f00d, 1'b0,  4};
    vecs[6]  = '{1'b1, 1'b1, 10'h40, 32'hcafe_f00d, 4'hf,  0, 1'b0, 32'h5a5a_c3c3, 1'b0,  3};
    vecs[7]  = '{1'b0, 1'b0, 10'h42, 32'h0,         4'h0,  0, 1'b0, 32'hcafe_f00d, 1'b0,  3};
    vecs[8]  = '{1'b1, 1'b0, 10'h30, 32'h0,         4'h0, 13, 1'b0, 32'h0000_00ab, 1'b0, 16};
    vecs[9]  = '{1'b1, 1'b0, 10'h34, 32'h0,         4'h0, 14, 1'b0, 32'h1234_0000, 1'b0, 17};
    vecs[10] = '{1'b0, 1'b0, 10'h50, 32'h0,         4'h0, 15, 1'b0, 32'h0000_0000, 1'b1, 17};
    vecs[11] = '{1'b1, 1'b0, 10'h30, 32'h0,         4'h0,  0, 1'b1, 32'h0000_0000, 1'b1, 17};
    vecs[12] = '{1'b0, 1'b0, 10'h30, 32'h0,         4'h0,  0, 1'b0, 32'h0000_00ab, 1'b0,  3};

    #12;
    chk("reset_outputs", all_outs(), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Stray slave ack while idle must be ignored.
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    chk("stray_ack_ignored", 128'({instr_ack, wb_ack, m_cyc, wb_stall}), 128'(0));
    @(posedge clk); #1;
    chk("stray_ack_quiet", 128'({instr_ack, wb_ack, m_cyc}), 128'(0));

    // Data cancel: drop wb_cyc while the slave is stalling.
    stall_cfg = 10;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_wr_en = 1'b0; wb_addr = 10'h34;
    repeat (3) begin @(posedge clk); #1; end
    chk("cancel_pre_cyc", 128'({m_cyc, m_stb}), 128'(3));
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("cancel_m_cyc_low", 128'({m_cyc, m_stb}), 128'(0));
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    chk("cancel_no_ack", 128'(acks), 128'(0));
    chk("cancel_idle_stall", 128'(wb_stall), 128'(0));
    stall_cfg = 0;

    // Reset in the middle of an instruction access.
    no_ack_cfg = 1'b1;
    instr_addr = 10'h30; instr_stb = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_pre_busy", 128'(m_cyc), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_in_instr_outputs", all_outs(), 128'(0));
    instr_stb = 1'b0; no_ack_cfg = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh reset: instruction port must win the first tie.
    tie_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
